// File: rtl/dmau_pkg.sv
// dmau_pkg: shared size encodings, FSM states and default depth for the data memory access unit
package dmau_pkg;
  localparam int DEPTH_DEF = 32;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  typedef enum logic [1:0] {IDLE, RD_WORD, WR_WORD, RESP} state_t;
endpackage

// File: rtl/dmau_if.sv
// dmau_if: CPU request/response handshake plus word-memory port of the data memory access unit
//   req_*    : CPU request (valid/ready, store flag, size, unsigned, byte address, store data)
//   rsp_*    : response (valid/ready, extended load data, error flag)
//   Addr, DataIn, RD, WD : word-indexed memory command; DataOut : combinational memory read data
//   master   : CPU + memory side; slave : the access unit
interface dmau_if #(parameter int AW = 32);
  logic req_valid, req_ready, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [AW-1:0] req_addr, Addr;
  logic [31:0] req_wdata, rsp_rdata, DataIn, DataOut;
  logic rsp_valid, rsp_ready, rsp_err, RD, WD;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, DataOut,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, Addr, DataIn, RD, WD
  );
  modport slave (
    input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, DataOut,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, Addr, DataIn, RD, WD
  );
endinterface

// File: rtl/lane_align.sv
// lane_align: little-endian sub-word store merge and load extract/extend
//   off    : byte offset addr[1:0]      size  : SZ_B/SZ_H/SZ_W
//   uns    : zero-extend loads          wdata : right-aligned store data
//   rword  : word read from memory      merged: rword with addressed lane(s) replaced
//   loaded : addressed lane shifted to bit 0 and extended
module lane_align
  import dmau_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] merged,
  output logic [31:0] loaded
);
  logic [4:0] sh;
  logic [31:0] mask;
  logic [15:0] lane;
  assign sh = {off, 3'b000};
  assign mask = size == SZ_B ? 32'hFF << sh : size == SZ_H ? 32'hFFFF << sh : '1;
  assign merged = (rword & ~mask) | ((wdata << sh) & mask);
  assign lane = 16'(rword >> sh);
  assign loaded = size == SZ_B ? {{24{!uns && lane[7]}}, lane[7:0]} :
                  size == SZ_H ? {{16{!uns && lane[15]}}, lane} : rword;
endmodule

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: sequences byte-addressed CPU loads/stores into word RD/WD memory accesses
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dmau_if slave (CPU req/rsp handshake and memory Addr/DataIn/RD/WD/DataOut)
module data_mem_access_unit
  import dmau_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = 32
) (
  input logic clk,
  input logic rst_n,
  dmau_if.slave bus
);
  state_t st, nxt;
  logic acc, bad, we, uns;
  logic [1:0] size, off;
  logic [31:0] wdata, merged, loaded;
  assign acc = bus.req_valid && st == IDLE;
  assign bad = bus.req_size == 2'd3 || (bus.req_size == SZ_H && bus.req_addr[0]) ||
               (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00) ||
               (bus.req_addr >> 2) >= AW'(DEPTH);
  // strobes decode straight from the state register so an async reset drops them at once
  assign bus.req_ready = st == IDLE;
  assign bus.rsp_valid = st == RESP;
  assign bus.RD = st == RD_WORD;
  assign bus.WD = st == WR_WORD;
  lane_align la (
    .off(off), .size(size), .uns(uns), .wdata(wdata), .rword(bus.DataOut),
    .merged(merged), .loaded(loaded)
  );
  always_comb begin
    nxt = st;
    if (st == IDLE)
      nxt = !acc ? IDLE : bad ? RESP : (bus.req_we && bus.req_size == SZ_W) ? WR_WORD : RD_WORD;
    else if (st == RD_WORD)
      nxt = we ? WR_WORD : RESP;
    else if (st == WR_WORD)
      nxt = RESP;
    else if (bus.rsp_ready)
      nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  // a word store writes req_wdata directly; sub-word stores overwrite DataIn with the merged word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we <= 1'b0;
      uns <= 1'b0;
      size <= SZ_B;
      off <= 2'b00;
      wdata <= '0;
      bus.Addr <= '0;
      bus.DataIn <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
    end else if (acc) begin
      we <= bus.req_we;
      uns <= bus.req_unsigned;
      size <= bus.req_size;
      off <= bus.req_addr[1:0];
      wdata <= bus.req_wdata;
      bus.Addr <= bus.req_addr >> 2;
      bus.DataIn <= bus.req_wdata;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= bad;
    end else if (st == RD_WORD) begin
      if (we) bus.DataIn <= merged;
      else bus.rsp_rdata <= loaded;
    end
endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb_data_mem_access_unit: directed and randomized checks of the access unit against a byte-level memory model
module tb_data_mem_access_unit;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [DEPTH] = '{default: 32'h1};
  logic [31:0] ref_mem [DEPTH] = '{default: 32'h1};
  logic [31:0] exp_rdata, exp_din, exp_addr;
  logic exp_err;
  int nrd, nwd, lat;
  logic [31:0] got_rdata, got_din, got_addr;
  logic got_err;
  int rd_cnt, wd_cnt;
  bit active = 0;
  bit r_we, r_uns;
  logic [1:0] r_sz;
  logic [31:0] r_addr, r_wd;
  int r_hold;

  dmau_if #(.AW(32)) bus();
  data_mem_access_unit #(.DEPTH(DEPTH), .AW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  assign bus.DataOut = bus.Addr < DEPTH ? mem[bus.Addr[4:0]] : 32'h0;
  always @(posedge clk) if (bus.WD && bus.Addr < DEPTH) mem[bus.Addr[4:0]] <= bus.DataIn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // expected outcome of one request, built from bytes of the reference memory
  task automatic model(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr, input logic [31:0] wd);
    int idx = int'(addr >> 2);
    int off = int'(addr[1:0]);
    logic [7:0] b [4];
    logic [15:0] h;
    exp_addr = addr >> 2;
    exp_err = sz == 3 || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0) || idx >= DEPTH;
    exp_rdata = 0; exp_din = 0; nrd = 0; nwd = 0; lat = 1;
    if (!exp_err) begin
      for (int i = 0; i < 4; i++) b[i] = ref_mem[idx][8*i +: 8];
      if (!we) begin
        nrd = 1; lat = 2;
        if (sz == 0) exp_rdata = uns ? {24'h0, b[off]} : {{24{b[off][7]}}, b[off]};
        else if (sz == 1) begin
          h = {b[off+1], b[off]};
          exp_rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
        end else exp_rdata = ref_mem[idx];
      end else begin
        nwd = 1; nrd = sz != 2 ? 1 : 0; lat = sz == 2 ? 2 : 3;
        b[off] = wd[7:0];
        if (sz >= 1) b[off+1] = wd[15:8];
        if (sz == 2) begin b[2] = wd[23:16]; b[3] = wd[31:24]; end
        exp_din = {b[3], b[2], b[1], b[0]};
        ref_mem[idx] = exp_din;
      end
    end
  endtask

  always @(negedge clk) if (rst_n && active) begin
    chk("rd_wd_excl", 32'(bus.RD & bus.WD), 0);
    if (bus.RD || bus.WD) chk("addr", bus.Addr, exp_addr);
    if (bus.WD) chk("datain", bus.DataIn, exp_din);
    if (bus.rsp_valid) begin
      chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
      chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    end
  end

  task automatic xact(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr, input logic [31:0] wd, input int hold);
    int n = 0;
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1; bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wd; bus.rsp_ready = hold == 0;
    model(we, sz, uns, addr, wd);
    active = 1; rd_cnt = 0; wd_cnt = 0; got_din = 'x; got_addr = 'x;
    @(posedge clk); #1;
    bus.req_valid = 0; bus.req_we = $urandom; bus.req_size = 2'($urandom);
    bus.req_unsigned = $urandom; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    while (n < 10) begin
      @(negedge clk); n++;
      rd_cnt += int'(bus.RD); wd_cnt += int'(bus.WD);
      if (bus.WD) begin got_din = bus.DataIn; got_addr = bus.Addr; end
      if (bus.rsp_valid) break;
    end
    chk("latency", n, lat);
    got_rdata = bus.rsp_rdata; got_err = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      rd_cnt += int'(bus.RD); wd_cnt += int'(bus.WD);
      chk("hold_valid", 32'(bus.rsp_valid), 1);
      chk("hold_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1;
    @(negedge clk);
    chk("rsp_drop", 32'(bus.rsp_valid), 0);
    active = 0;
    chk("rd_count", rd_cnt, nrd);
    chk("wd_count", wd_cnt, nwd);
    if (!exp_err) chk("mem_word", mem[exp_addr[4:0]], ref_mem[exp_addr[4:0]]);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 1;
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rd_wd", {30'b0, bus.RD, bus.WD}, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_addr", bus.Addr, 0);
    chk("rst_datain", bus.DataIn, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    xact(1, 1, 0, 32'h0A, 32'h8001, 0);
    chk("sh_mem", mem[2], 32'h80010001);
    xact(0, 1, 0, 32'h0A, 0, 0);
    chk("lh", got_rdata, 32'hFFFF8001);
    xact(0, 1, 1, 32'h0A, 0, 0);
    chk("lhu", got_rdata, 32'h00008001);
    xact(1, 2, 0, 32'h08, 32'hDEADBEEF, 0);
    chk("sw_din", got_din, 32'hDEADBEEF);
    chk("sw_addr", got_addr, 2);
    xact(0, 2, 0, 32'h08, 0, 0);
    chk("lw", got_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(got_err), 0);

    // async reset while the read half of a byte store is in flight
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_size = 0; bus.req_addr = 5; bus.req_wdata = 32'hAB;
    @(posedge clk); #1;
    bus.req_valid = 0;
    chk("rst_mid_rd_before", 32'(bus.RD), 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_rd", 32'(bus.RD), 0);
    chk("rst_mid_wd", 32'(bus.WD), 0);
    chk("rst_mid_rsp", 32'(bus.rsp_valid), 0);
    repeat (2) @(negedge clk);
    chk("rst_mid_wd_held", 32'(bus.WD), 0);
    rst_n = 1;
    chk("rst_mid_mem", mem[1], 32'h00000001);
    xact(0, 2, 0, 32'h04, 0, 0);
    chk("lw_after_rst", got_rdata, 32'h00000001);

    xact(1, 0, 0, 32'h05, 32'hAB, 0);
    chk("sb_din", got_din, 32'h0000AB01);
    chk("sb_addr", got_addr, 1);
    xact(0, 0, 0, 32'h05, 0, 0);
    chk("lb", got_rdata, 32'hFFFFFFAB);
    xact(0, 0, 1, 32'h05, 0, 0);
    chk("lbu", got_rdata, 32'h000000AB);

    xact(0, 1, 0, 32'h03, 0, 0);
    chk("err_lh3", 32'(got_err), 1);
    xact(1, 2, 0, 32'h06, 32'h1234, 0);
    chk("err_sw6", 32'(got_err), 1);
    xact(0, 2, 0, 32'h80, 0, 0);
    chk("err_lw80", 32'(got_err), 1);
    chk("err_rdata", got_rdata, 0);
    xact(0, 3, 0, 32'h00, 0, 0);
    chk("err_sz3", 32'(got_err), 1);

    xact(0, 2, 0, 32'h08, 0, 5);
    chk("hold_lw", got_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 300; i++) begin
      r_we = $urandom; r_uns = $urandom;
      r_sz = $urandom_range(0, 9) < 9 ? 2'($urandom % 3) : 2'd3;
      r_addr = $urandom_range(0, 4 * DEPTH + 15);
      r_wd = $urandom;
      r_hold = $urandom % 4 == 0 ? int'($urandom_range(1, 3)) : 0;
      xact(r_we, r_sz, r_uns, r_addr, r_wd, r_hold);
    end

    for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
